demux_14: RTL and testbench



---
 rtl/demux_14.sv | 122 ++++++++++++
 tb/tb_demux_14.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_14.sv
// rtl/demux_14.sv - four-lane round-robin deserializer for the 4-bit lane interface
//
// Purpose: collects four consecutive valid words from the serialized stream
// and presents them on four parallel lanes with one simultaneous valid pulse.
// Optional feature macro: DEMUX_14_FLUSH_EN (adds the flush port and frame_err).
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   data_in           serialized input word
//   valid_in          data_in is valid this cycle
//   flush             (DEMUX_14_FLUSH_EN only) emit the partial frame
//   data_0..data_3    registered lane output words
//   valid_0..valid_3  registered lane valids, one-cycle pulse per frame
//   frame_err         sticky: flush coincided with a completing 4th word
module demux_14 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
`ifdef DEMUX_14_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic             valid_0,
  output logic             valid_1,
  output logic             valid_2,
  output logic             valid_3,
  output logic             frame_err
);

  logic [1:0]       ptr;
  logic [WIDTH-1:0] stage    [4];
  logic [WIDTH-1:0] out_data [4];
  logic [3:0]       out_valid;
  logic             complete;

  // A valid word accepted at the last lane closes the frame.
  assign complete = valid_in && (ptr == 2'd3);

`ifdef DEMUX_14_FLUSH_EN
  logic [3:0]       mask;
  logic             err_r;
  logic [WIDTH-1:0] stage_nxt [4];
  logic [3:0]       mask_nxt;

  // Staging/mask as they will look after this cycle's word, so a flush
  // issued together with a valid word includes that word.
  always_comb begin
    stage_nxt = stage;
    mask_nxt  = mask;
    if (valid_in) begin
      stage_nxt[ptr] = data_in;
      mask_nxt[ptr]  = 1'b1;
    end
  end

  assign frame_err = err_r;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= 2'd0;
      out_valid <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        stage[k]    <= '0;
        out_data[k] <= '0;
      end
`ifdef DEMUX_14_FLUSH_EN
      mask  <= 4'd0;
      err_r <= 1'b0;
`endif
    end else begin
      out_valid <= 4'd0;
      if (valid_in) begin
        stage[ptr] <= data_in;
        ptr        <= ptr + 2'd1;   // wraps 3 -> 0 on completion
`ifdef DEMUX_14_FLUSH_EN
        mask[ptr]  <= 1'b1;
`endif
      end
      if (complete) begin
        // The 4th word bypasses staging straight to lane 3.
        out_data[0] <= stage[0];
        out_data[1] <= stage[1];
        out_data[2] <= stage[2];
        out_data[3] <= data_in;
        out_valid   <= 4'hF;
`ifdef DEMUX_14_FLUSH_EN
        mask <= 4'd0;
        if (flush) err_r <= 1'b1;
`endif
      end
`ifdef DEMUX_14_FLUSH_EN
      else if (flush && (mask_nxt != 4'd0)) begin
        for (int k = 0; k < 4; k++)
          out_data[k] <= mask_nxt[k] ? stage_nxt[k] : '0;
        out_valid <= mask_nxt;
        mask      <= 4'd0;
        ptr       <= 2'd0;
      end
`endif
    end
  end

  assign data_0  = out_data[0];
  assign data_1  = out_data[1];
  assign data_2  = out_data[2];
  assign data_3  = out_data[3];
  assign valid_0 = out_valid[0];
  assign valid_1 = out_valid[1];
  assign valid_2 = out_valid[2];
  assign valid_3 = out_valid[3];

endmodule

// File: tb/tb_demux_14.sv
// tb/tb_demux_14.sv - self-checking scoreboard bench for demux_14
module tb_demux_14;

  localparam int WIDTH = 4;
  localparam int OW    = 4 + 4 * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             flush_s;
  logic [WIDTH-1:0] data_0, data_1, data_2, data_3;
  logic             valid_0, valid_1, valid_2, valid_3;
  logic             frame_err;

  demux_14 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
`ifdef DEMUX_14_FLUSH_EN
    .flush    (flush_s),
`endif
    .data_0   (data_0),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .valid_0  (valid_0),
    .valid_1  (valid_1),
    .valid_2  (valid_2),
    .valid_3  (valid_3),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [1:0]       m_ptr;
  logic [WIDTH-1:0] m_stage [4];
  logic [3:0]       m_mask;

  logic [OW-1:0] obs;
  assign obs = {valid_3, valid_2, valid_1, valid_0, data_3, data_2, data_1, data_0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack(input logic [3:0] v, input logic [WIDTH-1:0] d3,
                                         input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d1,
                                         input logic [WIDTH-1:0] d0);
    return {v, d3, d2, d1, d0};
  endfunction

  // Scoreboard pop: any visible pulse must match the oldest expected frame
  // and appear exactly one cycle after the completing word was driven.
  always @(negedge clk) begin
    if (!reset && (valid_0 | valid_1 | valid_2 | valid_3)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'(obs), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("frame", 32'(obs), 32'(e.val));
        check("latency", cyc, e.cyc + 1);
      end
    end
  end

  task automatic model_clear();
    m_ptr  = 2'd0;
    m_mask = 4'd0;
    for (int k = 0; k < 4; k++) m_stage[k] = '0;
  endtask

  // Drive one cycle of stimulus and push any frame the model predicts.
  task automatic step(input logic [WIDTH-1:0] d, input logic v, input logic f);
    exp_t e;
    data_in  = d;
    valid_in = v;
    flush_s  = f;
    e.cyc    = cyc;
    if (v) begin
      m_stage[m_ptr] = d;
      m_mask[m_ptr]  = 1'b1;
      if (m_ptr == 2'd3) begin
        e.val = pack(4'hF, m_stage[3], m_stage[2], m_stage[1], m_stage[0]);
        q.push_back(e);
        m_mask = 4'd0;
        m_ptr  = 2'd0;
        f      = 1'b0;
      end else begin
        m_ptr = m_ptr + 2'd1;
      end
    end
    if (f && m_mask != 4'd0) begin
      e.val = pack(m_mask,
                   m_mask[3] ? m_stage[3] : '0, m_mask[2] ? m_stage[2] : '0,
                   m_mask[1] ? m_stage[1] : '0, m_mask[0] ? m_stage[0] : '0);
      q.push_back(e);
      m_mask = 4'd0;
      m_ptr  = 2'd0;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush_s  = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    flush_s  = 1'b0;
    data_in  = '0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    flush_s  = 1'b0;
    data_in  = '0;
    model_clear();
    @(posedge clk);
    do_reset();
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);

    // Basic frame, then hold with valid low.
    for (int i = 1; i <= 4; i++) step(WIDTH'(i), 1'b1, 1'b0);
    idle(1);
    check("held_after_pulse", 32'(obs), 32'(pack(4'h0, 4'h4, 4'h3, 4'h2, 4'h1)));
    idle(2);

    // Gaps inside a frame.
    step(4'hA, 1'b1, 1'b0);
    step(4'hB, 1'b1, 1'b0);
    idle(3);
    step(4'hC, 1'b1, 1'b0);
    step(4'hD, 1'b1, 1'b0);
    idle(2);

    // Back-to-back frames, pointer wrap.
    for (int i = 0; i < 8; i++) step(WIDTH'(i), 1'b1, 1'b0);
    idle(2);

    // Partial frame discarded by reset.
    step(4'h5, 1'b1, 1'b0);
    step(4'h6, 1'b1, 1'b0);
    do_reset();
    check("reset_clears_outputs", 32'(obs), 32'd0);
    step(4'h9, 1'b1, 1'b0);
    step(4'h8, 1'b1, 1'b0);
    step(4'h7, 1'b1, 1'b0);
    step(4'h6, 1'b1, 1'b0);
    idle(2);

    // Random stream with random gaps.
    for (int i = 0; i < 40; i++) step(WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    idle(2);
    check("frame_err_quiet", 32'(frame_err), 32'd0);

`ifdef DEMUX_14_FLUSH_EN
    do_reset();
    step(4'hE, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    check("flush_partial", 32'(obs), 32'(pack(4'h3, 4'h0, 4'h0, 4'hF, 4'hE)));
    step('0, 1'b0, 1'b1);
    check("flush_empty_noop", 32'({valid_3, valid_2, valid_1, valid_0}), 32'd0);
    for (int i = 1; i <= 4; i++) step(WIDTH'(i + 4), 1'b1, 1'b0);
    idle(1);
    check("frame_err_no_overlap", 32'(frame_err), 32'd0);
    step(4'h1, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    step(4'h4, 1'b1, 1'b1);
    check("frame_err_set", 32'(frame_err), 32'd1);
    idle(3);
    check("frame_err_sticky", 32'(frame_err), 32'd1);
    do_reset();
    check("frame_err_reset", 32'(frame_err), 32'd0);
    idle(1);
`endif

    idle(2);
    check("pending_frames", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
